// File: rtl/kyogenrv_pio_in.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | kyogenrv_pio_in: debounced, edge-capturing parallel input port (Avalon)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module kyogenrv_pio_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic             clk_riscv,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_EDGESEL = 2'd3;

  logic [WIDTH-1:0] sync_ff1;
  logic [WIDTH-1:0] sync_ff2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [1:0]       edge_sel;
  logic [31:0]      rd_word;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
      stable   <= '0;
    end else begin
      sync_ff1 <= pin_in;
      sync_ff2 <= sync_ff1;
      stable   <= stable_next;
    end
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
        assign stable_next[i] = sync_ff2[i];
      end else begin : g_db
        localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
        logic [CW-1:0] cnt;

        // Any return to the accepted level discards the partial count.
        always_ff @(posedge clk_riscv or negedge rst_in) begin
          if (!rst_in) begin
            cnt <= '0;
          end else if (sync_ff2[i] == stable[i]) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        assign stable_next[i] = (sync_ff2[i] != stable[i] && cnt == LAST) ? sync_ff2[i] : stable[i];
      end
    end
  endgenerate

  always_comb begin
    edge_hit = '0;
    case (edge_sel)
      2'b00:   edge_hit = stable_next & ~stable;
      2'b01:   edge_hit = ~stable_next & stable;
      default: edge_hit = stable_next ^ stable;
    endcase
  end

  assign cap_clr = (avs_write && avs_address == ADDR_EDGECAP) ? avs_writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_word = '0;
    case (avs_address)
      ADDR_DATA:    rd_word[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_word[WIDTH-1:0] = edge_cap;
      ADDR_EDGESEL: rd_word[1:0]       = edge_sel;
      default:      rd_word            = '0;
    endcase
  end

  // Read data comes from the pre-edge register state, so a read paired with a write sees the old value.
  always_ff @(posedge clk_riscv or negedge rst_in) begin
    if (!rst_in) begin
      irq_mask          <= '0;
      edge_sel          <= '0;
      edge_cap          <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (avs_write && avs_address == ADDR_IRQMASK) begin
        irq_mask <= avs_writedata[WIDTH-1:0];
      end
      if (avs_write && avs_address == ADDR_EDGESEL) begin
        edge_sel <= avs_writedata[1:0];
      end
      edge_cap          <= (edge_cap & ~cap_clr) | edge_hit;
      irq               <= |(edge_cap & irq_mask);
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kyogenrv_pio_in.sv
`default_nettype none
// Testbench for kyogenrv_pio_in: directed stimulus, read scoreboard drained by a monitor.
module tb_kyogenrv_pio_in;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  logic         clk_riscv = 1'b0;
  logic         rst_in;
  logic [W-1:0] pin_in;
  logic [1:0]   avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         irq;

  int   passed = 0;
  int   total  = 0;
  exp_t exp_q[$];

  kyogenrv_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk_riscv         (clk_riscv),
    .rst_in            (rst_in),
    .pin_in            (pin_in),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq)
  );

  always #5 clk_riscv = ~clk_riscv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_riscv);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick(1);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.val = exp; e.name = name;
    exp_q.push_back(e);
    avs_address = a; avs_read = 1'b1;
    tick(1);
    avs_read = 1'b0;
  endtask

  task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
    exp_t e;
    e.val = exp; e.name = name;
    exp_q.push_back(e);
    avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
    tick(1);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expected read.
  always @(negedge clk_riscv) begin
    if (avs_readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: got valid with data 0x%08h, expected no read at %0t", avs_readdata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.name, avs_readdata, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; pin_in = '0; avs_address = '0; avs_read = 1'b0;
    avs_write = 1'b0; avs_writedata = '0;
    tick(3);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_valid", {31'b0, avs_readdatavalid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_in = 1'b1;
    tick(2);
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h0, "rst_mask");
    rd(2'd2, 32'h0, "rst_cap");
    rd(2'd3, 32'h0, "rst_sel");

    // Debounced press: stable and EDGECAP at edge 6, irq at edge 7.
    wr(2'd3, 32'h0);
    wr(2'd1, 32'h1);
    pin_in = 8'h01;
    tick(5);
    rd(2'd0, 32'h0, "press_data_edge6_old");
    chk("press_irq_edge6", {31'b0, irq}, 32'h0);
    rd(2'd0, 32'h1, "press_data_edge7");
    chk("press_irq_edge7", {31'b0, irq}, 32'h1);
    rd(2'd2, 32'h1, "press_cap");

    // Glitch rejection: 3-cycle pulse on pin 3.
    wr(2'd2, 32'hFF);
    pin_in = 8'h09;
    tick(3);
    pin_in = 8'h01;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("glitch_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd0, 32'h1, "glitch_data");
    rd(2'd2, 32'h0, "glitch_cap");

    // W1C and mask following.
    wr(2'd3, 32'h2);
    pin_in = 8'h04;
    tick(10);
    rd(2'd2, 32'h5, "w1c_cap_before");
    chk("w1c_irq_before", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h1, "w1c_cap_after");
    chk("w1c_irq_after", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h4);
    tick(1);
    chk("w1c_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd1, 32'h1);
    tick(1);
    chk("w1c_irq_unmasked", {31'b0, irq}, 32'h1);
    wr(2'd2, 32'h1);
    tick(1);
    chk("w1c_irq_cleared", {31'b0, irq}, 32'h0);
    rd(2'd2, 32'h0, "w1c_cap_cleared");

    // Set wins over a simultaneous clear: clear write sampled on the set edge.
    pin_in = 8'h05;
    tick(5);
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1, "collision_set_wins");

    // Edge selection on pin 2.
    wr(2'd2, 32'hFF);
    wr(2'd3, 32'h0);
    pin_in = 8'h01;
    tick(10);
    rd(2'd2, 32'h0, "sel_rise_ignores_fall");
    wr(2'd3, 32'h1);
    pin_in = 8'h05;
    tick(10);
    rd(2'd2, 32'h0, "sel_fall_ignores_rise");
    pin_in = 8'h01;
    tick(10);
    rd(2'd2, 32'h4, "sel_fall_catches_fall");
    wr(2'd2, 32'hFF);
    wr(2'd3, 32'h2);
    pin_in = 8'h05;
    tick(10);
    rd(2'd2, 32'h4, "sel_both_rise");
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0, "sel_both_cleared");
    pin_in = 8'h01;
    tick(10);
    rd(2'd2, 32'h4, "sel_both_fall");
    wr(2'd2, 32'hFF);

    // Masking, back-to-back reads, read+write collision.
    pin_in = 8'hFE;
    tick(10);
    wr(2'd1, 32'h0);
    tick(1);
    chk("mask0_irq", {31'b0, irq}, 32'h0);
    rd(2'd2, 32'hFF, "mask_cap_all");
    wr(2'd1, 32'h80);
    chk("mask80_irq_same", {31'b0, irq}, 32'h0);
    tick(1);
    chk("mask80_irq_next", {31'b0, irq}, 32'h1);
    rd(2'd0, 32'hFE, "b2b_data");
    rd(2'd1, 32'h80, "b2b_mask");
    rd(2'd2, 32'hFF, "b2b_cap");
    rd(2'd3, 32'h2, "b2b_sel");
    rdwr(2'd1, 32'h12, 32'h80, "rdwr_old_value");
    rd(2'd1, 32'h12, "rdwr_new_value");

    // Reset mid-operation with EDGECAP=0x10 and pin 5 counter at 2.
    wr(2'd2, 32'hFF);
    wr(2'd1, 32'h10);
    pin_in = 8'hEE;
    tick(10);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    pin_in = 8'hCE;
    tick(4);
    rst_in = 1'b0;
    #1;
    chk("async_rst_irq", {31'b0, irq}, 32'h0);
    chk("async_rst_readdata", avs_readdata, 32'h0);
    chk("async_rst_valid", {31'b0, avs_readdatavalid}, 32'h0);
    pin_in = 8'h00;
    tick(3);
    rst_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("post_rst_irq", {31'b0, irq}, 32'h0);
    end
    rd(2'd2, 32'h0, "post_rst_cap");
    rd(2'd0, 32'h0, "post_rst_data");
    rd(2'd1, 32'h0, "post_rst_mask");
    rd(2'd3, 32'h0, "post_rst_sel");

    tick(3);
    chk("sb_drain", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
